// File: rtl/tow_pkg.sv
// tow_pkg: shared types and constants for the tug-of-war controller.
//   state_t   - controller FSM states
//   score_t   - per-player round-win counter
//   winner_t  - round winner code (WIN_NONE / WIN_L / WIN_R)
//   WIN_SCORE - rounds needed to take the game
//   HOLD_CYCLES - default length of the post-win display hold
package tow_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    PLAY  = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [2:0] score_t;
  typedef logic [1:0] winner_t;

  localparam int     WIN_SCORE   = 7;
  localparam int     HOLD_CYCLES = 8;
  localparam score_t WIN_SCORE_V = score_t'(WIN_SCORE);

  localparam winner_t WIN_NONE = 2'b00;
  localparam winner_t WIN_L    = 2'b01;
  localparam winner_t WIN_R    = 2'b10;

endpackage

// File: rtl/tug_of_war_ctrl_if.sv
// tug_of_war_ctrl_if: bundle of player keys, playfield feedback and
// controller outputs.
//   key_l/key_r       - raw player buttons (asynchronous to clk)
//   edge_l/edge_r     - leftmost/rightmost playfield light state
//   press_l/press_r   - one-cycle move pulses to the playfield
//   field_reset       - playfield synchronous reset
//   score_l/score_r   - round wins per player
//   winner            - round winner code
//   game_over         - a player has reached the winning score
// Modports: slave = controller side, master = environment side.
interface tug_of_war_ctrl_if;
  import tow_pkg::*;

  logic    key_l;
  logic    key_r;
  logic    edge_l;
  logic    edge_r;
  logic    press_l;
  logic    press_r;
  logic    field_reset;
  score_t  score_l;
  score_t  score_r;
  winner_t winner;
  logic    game_over;

  modport slave (
    input  key_l, key_r, edge_l, edge_r,
    output press_l, press_r, field_reset, score_l, score_r, winner, game_over
  );

  modport master (
    output key_l, key_r, edge_l, edge_r,
    input  press_l, press_r, field_reset, score_l, score_r, winner, game_over
  );

endinterface

// File: rtl/key_edge.sv
// key_edge: two-flop synchronizer followed by a registered rising-edge
// detector for one player button.
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   i_key - raw button, asynchronous to clk
//   o_evt - one-cycle press event; key high at edge k gives o_evt high
//           from edge k+2 to edge k+3
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_key,
  output logic o_evt
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_evt   <= 1'b0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      // Registered so the event is a clean flop output, one cycle wide.
      r_evt   <= r_sync2 & ~r_prev;
    end
  end

  assign o_evt = r_evt;

endmodule

// File: rtl/tug_of_war_ctrl.sv
// tug_of_war_ctrl: game controller for a tug-of-war light playfield.
// Debounced-by-sync press events move the light while in PLAY; a press
// that pushes the light off an edge wins the round. After a win the
// result is held for P_HOLD_CYCLES cycles, then the field is cleared,
// until one player reaches WIN_SCORE and the game locks in DONE.
//   clk           - rising-edge clock
//   reset         - asynchronous active-high reset
//   bus (slave)   - keys, edge lights and all controller outputs
//   P_HOLD_CYCLES - length of the post-win hold (overridable)
module tug_of_war_ctrl
  import tow_pkg::*;
#(
  parameter int P_HOLD_CYCLES = HOLD_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  tug_of_war_ctrl_if.slave   bus
);

  localparam int CW = (P_HOLD_CYCLES > 1) ? $clog2(P_HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(P_HOLD_CYCLES - 1);

  logic w_evt_l;
  logic w_evt_r;

  key_edge u_key_l (
    .clk   (clk),
    .reset (reset),
    .i_key (bus.key_l),
    .o_evt (w_evt_l)
  );

  key_edge u_key_r (
    .clk   (clk),
    .reset (reset),
    .i_key (bus.key_r),
    .o_evt (w_evt_r)
  );

  state_t        r_state;
  logic [CW-1:0] r_hold_cnt;
  score_t        r_score_l;
  score_t        r_score_r;
  winner_t       r_winner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= CLEAR;
      r_hold_cnt <= '0;
      r_score_l  <= '0;
      r_score_r  <= '0;
      r_winner   <= WIN_NONE;
    end else begin
      case (r_state)
        CLEAR: begin
          r_winner <= WIN_NONE;
          r_state  <= PLAY;
        end
        PLAY: begin
          // A simultaneous press is a non-move, so it can never win.
          if (w_evt_l && !w_evt_r && bus.edge_l) begin
            r_state    <= HOLD;
            r_score_l  <= r_score_l + 3'd1;
            r_winner   <= WIN_L;
            r_hold_cnt <= HOLD_LOAD;
          end else if (w_evt_r && !w_evt_l && bus.edge_r) begin
            r_state    <= HOLD;
            r_score_r  <= r_score_r + 3'd1;
            r_winner   <= WIN_R;
            r_hold_cnt <= HOLD_LOAD;
          end
        end
        HOLD: begin
          if (r_hold_cnt == '0) begin
            if (r_score_l == WIN_SCORE_V || r_score_r == WIN_SCORE_V) begin
              r_state <= DONE;
            end else begin
              // Drop the winner now so it shows for exactly the hold time.
              r_state  <= CLEAR;
              r_winner <= WIN_NONE;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt - CW'(1);
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= CLEAR;
        end
      endcase
    end
  end

  // Outputs decode only registered state; events outside PLAY are dropped.
  assign bus.press_l     = (r_state == PLAY) && w_evt_l;
  assign bus.press_r     = (r_state == PLAY) && w_evt_r;
  assign bus.field_reset = (r_state == CLEAR) || (r_state == DONE);
  assign bus.game_over   = (r_state == DONE);
  assign bus.score_l     = r_score_l;
  assign bus.score_r     = r_score_r;
  assign bus.winner      = r_winner;

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// tb_tug_of_war_ctrl: directed bench for tug_of_war_ctrl. Expected press
// pulses (cycle and value) go into a scoreboard queue when keys are driven
// and are popped by a monitor whenever a pulse appears; status outputs are
// checked at fixed points in the step sequence.
module tb_tug_of_war_ctrl;

  localparam int HC = 4;

  typedef struct {
    int         cyc;
    logic [1:0] lr;   // {press_l, press_r}
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  exp_t exp_q[$];

  tug_of_war_ctrl_if bus ();

  tug_of_war_ctrl #(.P_HOLD_CYCLES(HC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse monitor: every observed press pulse must match the head of the queue.
  always @(posedge clk) begin
    #1;
    if (bus.press_l || bus.press_r) begin
      if (exp_q.size() == 0) begin
        check("press_unexpected", {30'd0, bus.press_l, bus.press_r}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("press_cycle", cyc, e.cyc);
        check("press_value", {30'd0, bus.press_l, bus.press_r}, {30'd0, e.lr});
        $display("press pulse at cycle %0d: l=%0b r=%0b", cyc, bus.press_l, bus.press_r);
      end
    end
  end

  // One full round win for one side; optionally pokes the other key in HOLD.
  task automatic win(input bit right, input logic [2:0] exp_score, input bit final_win,
                     input bit poke);
    @(negedge clk);
    if (right) begin bus.key_r = 1'b1; bus.edge_r = 1'b1; end
    else       begin bus.key_l = 1'b1; bus.edge_l = 1'b1; end
    exp_q.push_back('{cyc + 3, right ? 2'b01 : 2'b10});
    wait_neg(1);
    bus.key_l = 1'b0; bus.key_r = 1'b0;
    wait_neg(3);   // first HOLD cycle
    check(right ? "score_r_win" : "score_l_win",
          {29'd0, right ? bus.score_r : bus.score_l}, {29'd0, exp_score});
    check("winner_hold_first", {30'd0, bus.winner}, right ? 32'd2 : 32'd1);
    check("field_reset_hold", {31'd0, bus.field_reset}, 32'd0);
    bus.edge_l = 1'b0; bus.edge_r = 1'b0;
    wait_neg(1);
    if (poke) begin
      if (right) bus.key_l = 1'b1; else bus.key_r = 1'b1;
    end
    wait_neg(2);   // last HOLD cycle
    check("winner_hold_last", {30'd0, bus.winner}, right ? 32'd2 : 32'd1);
    wait_neg(1);
    if (final_win) begin
      check("game_over_done", {31'd0, bus.game_over}, 32'd1);
      check("field_reset_done", {31'd0, bus.field_reset}, 32'd1);
      check("winner_done", {30'd0, bus.winner}, right ? 32'd2 : 32'd1);
    end else begin
      check("field_reset_clear", {31'd0, bus.field_reset}, 32'd1);
      check("winner_clear", {30'd0, bus.winner}, 32'd0);
      check("game_over_clear", {31'd0, bus.game_over}, 32'd0);
    end
    wait_neg(1);
    check("field_reset_after", {31'd0, bus.field_reset}, final_win ? 32'd1 : 32'd0);
    if (!final_win) check("winner_play", {30'd0, bus.winner}, 32'd0);
    $display("round win %s score=%0d final=%0b", right ? "R" : "L", exp_score, final_win);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.key_l = 1'b0; bus.key_r = 1'b0;
    bus.edge_l = 1'b0; bus.edge_r = 1'b0;

    // Reset then idle.
    wait_neg(3);
    reset = 1'b0;
    #1;
    check("rst_field_reset_first", {31'd0, bus.field_reset}, 32'd1);
    check("rst_score_l", {29'd0, bus.score_l}, 32'd0);
    check("rst_score_r", {29'd0, bus.score_r}, 32'd0);
    check("rst_winner", {30'd0, bus.winner}, 32'd0);
    check("rst_game_over", {31'd0, bus.game_over}, 32'd0);
    check("rst_press", {30'd0, bus.press_l, bus.press_r}, 32'd0);
    wait_neg(1);
    check("idle_field_reset", {31'd0, bus.field_reset}, 32'd0);
    wait_neg(4);
    check("idle_field_reset_late", {31'd0, bus.field_reset}, 32'd0);
    $display("reset and idle done at cycle %0d", cyc);

    // Held key gives exactly one pulse.
    @(negedge clk);
    bus.key_l = 1'b1;
    exp_q.push_back('{cyc + 3, 2'b10});
    wait_neg(10);
    bus.key_l = 1'b0;
    wait_neg(3);
    check("held_key_score", {29'd0, bus.score_l}, 32'd0);

    // Left win; right key poked in HOLD must be consumed, not queued.
    win(1'b0, 3'd1, 1'b0, 1'b1);
    wait_neg(4);
    bus.key_r = 1'b0;
    wait_neg(3);
    check("poke_no_score_r", {29'd0, bus.score_r}, 32'd0);

    // Simultaneous press with light at right edge: no win.
    @(negedge clk);
    bus.edge_r = 1'b1;
    bus.key_l = 1'b1; bus.key_r = 1'b1;
    exp_q.push_back('{cyc + 3, 2'b11});
    wait_neg(6);
    check("simul_score_l", {29'd0, bus.score_l}, 32'd1);
    check("simul_score_r", {29'd0, bus.score_r}, 32'd0);
    check("simul_winner", {30'd0, bus.winner}, 32'd0);
    check("simul_still_play", {31'd0, bus.field_reset}, 32'd0);
    bus.key_l = 1'b0; bus.key_r = 1'b0; bus.edge_r = 1'b0;
    wait_neg(3);

    // Light at edge with no press is not a win.
    bus.edge_l = 1'b1;
    wait_neg(6);
    check("edge_only_score", {29'd0, bus.score_l}, 32'd1);
    check("edge_only_winner", {30'd0, bus.winner}, 32'd0);
    bus.edge_l = 1'b0;
    wait_neg(2);

    // Reach score_l=3 and reset in the middle of that HOLD.
    win(1'b0, 3'd2, 1'b0, 1'b0);
    @(negedge clk);
    bus.key_l = 1'b1; bus.edge_l = 1'b1;
    exp_q.push_back('{cyc + 3, 2'b10});
    wait_neg(1);
    bus.key_l = 1'b0;
    wait_neg(4);
    check("pre_reset_score_l", {29'd0, bus.score_l}, 32'd3);
    check("pre_reset_winner", {30'd0, bus.winner}, 32'd1);
    bus.edge_l = 1'b0;
    reset = 1'b1;
    #1;
    check("midhold_rst_score_l", {29'd0, bus.score_l}, 32'd0);
    check("midhold_rst_winner", {30'd0, bus.winner}, 32'd0);
    check("midhold_rst_field", {31'd0, bus.field_reset}, 32'd1);
    wait_neg(2);
    reset = 1'b0;
    #1;
    check("post_rst_clear", {31'd0, bus.field_reset}, 32'd1);
    wait_neg(1);
    check("post_rst_play", {31'd0, bus.field_reset}, 32'd0);
    check("post_rst_winner", {30'd0, bus.winner}, 32'd0);
    $display("mid-hold reset done at cycle %0d", cyc);

    // Seven right wins end the game.
    for (int i = 1; i <= 7; i++) begin
      win(1'b1, 3'(i), i == 7, 1'b0);
    end

    // DONE ignores keys and keeps the scores.
    @(negedge clk);
    bus.key_l = 1'b1; bus.key_r = 1'b1; bus.edge_l = 1'b1;
    wait_neg(4);
    bus.key_l = 1'b0; bus.key_r = 1'b0;
    wait_neg(2);
    bus.key_r = 1'b1;
    wait_neg(6);
    check("done_score_r", {29'd0, bus.score_r}, 32'd7);
    check("done_score_l", {29'd0, bus.score_l}, 32'd0);
    check("done_game_over", {31'd0, bus.game_over}, 32'd1);
    check("done_field_reset", {31'd0, bus.field_reset}, 32'd1);
    check("done_winner", {30'd0, bus.winner}, 32'd2);
    bus.key_r = 1'b0; bus.edge_l = 1'b0;

    // Key held through reset release yields one pulse.
    bus.key_l = 1'b1;
    reset = 1'b1;
    #1;
    check("final_rst_game_over", {31'd0, bus.game_over}, 32'd0);
    check("final_rst_score_r", {29'd0, bus.score_r}, 32'd0);
    wait_neg(2);
    reset = 1'b0;
    exp_q.push_back('{cyc + 3, 2'b10});
    wait_neg(8);
    bus.key_l = 1'b0;
    wait_neg(4);
    check("held_thru_rst_score", {29'd0, bus.score_l}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
